// File: rtl/bus_target_responder_pkg.sv
// Shared types and constants for the bus target responder.
// Holds the FSM state encoding and the default bus width and timeout read value.
package bus_target_responder_pkg;

  localparam int WORD_W = 16;
  localparam logic [WORD_W-1:0] TIMEOUT_VAL = 16'hDEAD;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_UWR,
    S_URD,
    S_RDATA
  } state_t;

endpackage

// File: rtl/bus_target_responder_if.sv
// Interconnect and user-port signal bundle for the bus target responder.
// Signal names are from the responder's view; slave = responder, master = environment.
interface bus_target_responder_if #(
  parameter int W = 16
);
  logic         i_addr_valid;
  logic         i_write_enable;
  logic         i_write_data_valid;
  logic         o_addr_ready;
  logic         o_write_data_ready;
  logic         o_read_data_valid;
  logic         i_read_data_ready;
  logic [W-1:0] i_common;
  logic [W-1:0] o_read_data;
  logic         o_user_req;
  logic         o_user_we;
  logic [W-1:0] o_user_addr;
  logic [W-1:0] o_user_wdata;
  logic         i_user_ack;
  logic [W-1:0] i_user_rdata;
  logic         o_timeout;

  modport slave (
    input  i_addr_valid, i_write_enable,
    input  i_write_data_valid, i_read_data_ready,
    input  i_common, i_user_ack, i_user_rdata,
    output o_addr_ready, o_write_data_ready,
    output o_read_data_valid, o_read_data,
    output o_user_req, o_user_we,
    output o_user_addr, o_user_wdata, o_timeout
  );

  modport master (
    output i_addr_valid, i_write_enable,
    output i_write_data_valid, i_read_data_ready,
    output i_common, i_user_ack, i_user_rdata,
    input  o_addr_ready, o_write_data_ready,
    input  o_read_data_valid, o_read_data,
    input  o_user_req, o_user_we,
    input  o_user_addr, o_user_wdata, o_timeout
  );
endinterface

// File: rtl/bus_target_responder.sv
// Target side of the control interconnect: one bus transaction -> one user request.
// Ports: clk, reset (sync, active-high), bus (slave modport: handshakes + user port).
module bus_target_responder
  import bus_target_responder_pkg::*;
#(
  parameter int WORD_WIDTH = WORD_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [WORD_WIDTH-1:0] TIMEOUT_VALUE = TIMEOUT_VAL
) (
  input logic clk,
  input logic reset,
  bus_target_responder_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  state_t                r_state, w_state_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic [WORD_WIDTH-1:0] r_addr, w_addr_nx;
  logic [WORD_WIDTH-1:0] r_wdata, w_wdata_nx;
  logic [WORD_WIDTH-1:0] r_rdata, w_rdata_nx;
  logic                  r_we, w_we_nx;
  logic                  r_timeout, w_timeout_nx;
  logic                  r_addr_ready;
  logic                  r_wdata_ready;
  logic                  r_rvalid;
  logic                  r_req;
  logic                  r_user_we;
  logic                  w_in_user;

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_addr_nx    = r_addr;
    w_wdata_nx   = r_wdata;
    w_rdata_nx   = r_rdata;
    w_we_nx      = r_we;
    w_timeout_nx = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.i_addr_valid) begin
          w_addr_nx  = bus.i_common;
          w_we_nx    = bus.i_write_enable;
          w_cnt_nx   = '0;
          w_state_nx = bus.i_write_enable ? S_WDATA : S_URD;
        end
      end
      S_WDATA: begin
        if (bus.i_write_data_valid) begin
          w_wdata_nx = bus.i_common;
          w_cnt_nx   = '0;
          w_state_nx = S_UWR;
        end
      end
      S_UWR, S_URD: begin
        // ack on the terminal-count cycle still completes normally
        if (bus.i_user_ack) begin
          if (r_state == S_URD) begin
            w_rdata_nx = bus.i_user_rdata;
            w_state_nx = S_RDATA;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else if (r_cnt == LAST) begin
          w_timeout_nx = 1'b1;
          if (r_state == S_URD) begin
            w_rdata_nx = TIMEOUT_VALUE;
            w_state_nx = S_RDATA;
          end else begin
            w_state_nx = S_IDLE;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_RDATA: begin
        if (bus.i_read_data_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // outputs are registered copies decoded from the next state
  assign w_in_user = (w_state_nx == S_UWR) || (w_state_nx == S_URD);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_rdata       <= '0;
      r_we          <= 1'b0;
      r_timeout     <= 1'b0;
      r_addr_ready  <= 1'b1;
      r_wdata_ready <= 1'b0;
      r_rvalid      <= 1'b0;
      r_req         <= 1'b0;
      r_user_we     <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_cnt         <= w_cnt_nx;
      r_addr        <= w_addr_nx;
      r_wdata       <= w_wdata_nx;
      r_rdata       <= w_rdata_nx;
      r_we          <= w_we_nx;
      r_timeout     <= w_timeout_nx;
      r_addr_ready  <= (w_state_nx == S_IDLE);
      r_wdata_ready <= (w_state_nx == S_WDATA);
      r_rvalid      <= (w_state_nx == S_RDATA);
      r_req         <= w_in_user;
      r_user_we     <= w_in_user && w_we_nx;
    end
  end

  assign bus.o_addr_ready       = r_addr_ready;
  assign bus.o_write_data_ready = r_wdata_ready;
  assign bus.o_read_data_valid  = r_rvalid;
  assign bus.o_read_data        = r_rdata;
  assign bus.o_user_req         = r_req;
  assign bus.o_user_we          = r_user_we;
  assign bus.o_user_addr        = r_addr;
  assign bus.o_user_wdata       = r_wdata;
  assign bus.o_timeout          = r_timeout;

endmodule

// File: tb/tb_bus_target_responder.sv
// Self-checking bench for bus_target_responder.
// Scoreboard queues hold expected user requests and read results.
module tb_bus_target_responder;
  import bus_target_responder_pkg::*;

  localparam int W = 16;

  typedef struct packed {
    logic         we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
  } req_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_pass = 0;
  int   n_tot = 0;
  req_t req_q[$];
  logic [W-1:0] rd_q[$];

  always #5 clk = ~clk;

  bus_target_responder_if #(.W(W)) bus ();

  bus_target_responder #(
    .WORD_WIDTH(W),
    .TIMEOUT_CYCLES(255),
    .TIMEOUT_VALUE(16'hDEAD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  function automatic logic [53:0] snap();
    return {bus.o_addr_ready, bus.o_write_data_ready,
            bus.o_read_data_valid, bus.o_read_data,
            bus.o_user_req, bus.o_user_we, bus.o_user_addr,
            bus.o_user_wdata, bus.o_timeout};
  endfunction

  task automatic idle_inputs();
    bus.i_addr_valid       = 1'b0;
    bus.i_write_enable     = 1'b0;
    bus.i_write_data_valid = 1'b0;
    bus.i_read_data_ready  = 1'b0;
    bus.i_common           = '0;
    bus.i_user_ack         = 1'b0;
    bus.i_user_rdata       = '0;
  endtask

  task automatic addr_hs(input logic [W-1:0] a, input logic we);
    @(negedge clk);
    bus.i_addr_valid   = 1'b1;
    bus.i_common       = a;
    bus.i_write_enable = we;
    @(negedge clk);
    bus.i_addr_valid   = 1'b0;
    bus.i_write_enable = 1'b0;
    bus.i_common       = '0;
  endtask

  task automatic wdata_hs(input logic [W-1:0] d);
    @(negedge clk);
    bus.i_write_data_valid = 1'b1;
    bus.i_common           = d;
    @(negedge clk);
    bus.i_write_data_valid = 1'b0;
    bus.i_common           = '0;
  endtask

  task automatic ready_hs();
    bus.i_read_data_ready = 1'b1;
    @(negedge clk);
    bus.i_read_data_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [53:0] exp;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp = '0;
    exp[53] = 1'b1;
    n_tot++;
    if (snap() !== exp)
      $display("FAIL reset_state: got %h want %h", snap(), exp);
    else n_pass++;
  endtask

  task automatic test_write();
    req_t e, g;
    addr_hs(16'h0010, 1'b1);
    n_tot++;
    if ({bus.o_write_data_ready, bus.o_addr_ready} !== 2'b10)
      $display("FAIL wr_wdata_ready: got %b want 10",
               {bus.o_write_data_ready, bus.o_addr_ready});
    else n_pass++;
    req_q.push_back('{we: 1'b1, addr: 16'h0010, wdata: 16'h1234});
    wdata_hs(16'h1234);
    e = req_q.pop_front();
    g = '{we: bus.o_user_we, addr: bus.o_user_addr,
          wdata: bus.o_user_wdata};
    n_tot++;
    if (!bus.o_user_req || g !== e)
      $display("FAIL wr_req: got req=%b %h want req=1 %h",
               bus.o_user_req, g, e);
    else n_pass++;
    bus.i_user_ack = 1'b1;
    @(negedge clk);
    bus.i_user_ack = 1'b0;
    n_tot++;
    if ({bus.o_user_req, bus.o_addr_ready} !== 2'b01)
      $display("FAIL wr_ack_idle: got req,ardy=%b want 01",
               {bus.o_user_req, bus.o_addr_ready});
    else n_pass++;
  endtask

  task automatic test_read();
    logic [W-1:0] e;
    int bad;
    addr_hs(16'h0020, 1'b0);
    n_tot++;
    if ({bus.o_user_req, bus.o_user_we, bus.o_user_addr}
        !== {2'b10, 16'h0020})
      $display("FAIL rd_req: got %b %b %h want 1 0 0020",
               bus.o_user_req, bus.o_user_we, bus.o_user_addr);
    else n_pass++;
    repeat (3) @(negedge clk);
    bus.i_user_ack   = 1'b1;
    bus.i_user_rdata = 16'hBEEF;
    rd_q.push_back(16'hBEEF);
    @(negedge clk);
    bus.i_user_ack   = 1'b0;
    bus.i_user_rdata = '0;
    e = rd_q.pop_front();
    n_tot++;
    if (!bus.o_read_data_valid || bus.o_read_data !== e)
      $display("FAIL rd_data: got v=%b %h want v=1 %h",
               bus.o_read_data_valid, bus.o_read_data, e);
    else n_pass++;
    bad = 0;
    repeat (2) begin
      @(negedge clk);
      if (!bus.o_read_data_valid || bus.o_read_data !== e) bad++;
    end
    n_tot++;
    if (bad != 0)
      $display("FAIL rd_hold: got %0d bad cycles want 0", bad);
    else n_pass++;
    ready_hs();
    n_tot++;
    if ({bus.o_read_data_valid, bus.o_addr_ready, bus.o_read_data}
        !== {2'b01, e})
      $display("FAIL rd_done: got %b %b %h want 0 1 %h",
               bus.o_read_data_valid, bus.o_addr_ready,
               bus.o_read_data, e);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [W-1:0] e;
    int bad;
    addr_hs(16'h0030, 1'b0);
    bus.i_user_ack   = 1'b1;
    bus.i_user_rdata = 16'h5A5A;
    rd_q.push_back(16'h5A5A);
    @(negedge clk);
    bus.i_user_ack   = 1'b0;
    bus.i_user_rdata = '0;
    e = rd_q.pop_front();
    bus.i_addr_valid = 1'b1;
    bus.i_common     = 16'h1111;
    bad = 0;
    repeat (5) begin
      if (!bus.o_read_data_valid || bus.o_read_data !== e ||
          bus.o_addr_ready || bus.o_user_req) bad++;
      @(negedge clk);
    end
    n_tot++;
    if (bad != 0)
      $display("FAIL bp_stable: got %0d bad cycles want 0", bad);
    else n_pass++;
    bus.i_addr_valid = 1'b0;
    bus.i_common     = '0;
    ready_hs();
    n_tot++;
    if ({bus.o_read_data_valid, bus.o_addr_ready, bus.o_user_req}
        !== 3'b010)
      $display("FAIL bp_done: got %b want 010",
               {bus.o_read_data_valid, bus.o_addr_ready,
                bus.o_user_req});
    else n_pass++;
  endtask

  task automatic test_timeout_read();
    logic [W-1:0] e;
    int cyc;
    addr_hs(16'h0040, 1'b0);
    rd_q.push_back(16'hDEAD);
    cyc = 0;
    while (bus.o_user_req && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    e = rd_q.pop_front();
    n_tot++;
    if (cyc != 255)
      $display("FAIL to_rd_cycles: got %0d want 255", cyc);
    else n_pass++;
    n_tot++;
    if ({bus.o_timeout, bus.o_read_data_valid, bus.o_read_data}
        !== {2'b11, e})
      $display("FAIL to_rd_result: got %b %b %h want 1 1 %h",
               bus.o_timeout, bus.o_read_data_valid,
               bus.o_read_data, e);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (bus.o_timeout !== 1'b0)
      $display("FAIL to_rd_pulse: got %b want 0", bus.o_timeout);
    else n_pass++;
    ready_hs();
  endtask

  task automatic test_timeout_write();
    int cyc;
    addr_hs(16'h0050, 1'b1);
    wdata_hs(16'h7777);
    cyc = 0;
    while (bus.o_user_req && cyc < 400) begin
      cyc++;
      @(negedge clk);
    end
    n_tot++;
    if (cyc != 255 || {bus.o_timeout, bus.o_addr_ready} !== 2'b11)
      $display("FAIL to_wr: got cyc=%0d to,ardy=%b want 255 11",
               cyc, {bus.o_timeout, bus.o_addr_ready});
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (bus.o_timeout !== 1'b0)
      $display("FAIL to_wr_pulse: got %b want 0", bus.o_timeout);
    else n_pass++;
  endtask

  task automatic test_ack_terminal();
    logic [W-1:0] e;
    addr_hs(16'h0070, 1'b0);
    repeat (254) @(negedge clk);
    bus.i_user_ack   = 1'b1;
    bus.i_user_rdata = 16'hC0DE;
    rd_q.push_back(16'hC0DE);
    @(negedge clk);
    bus.i_user_ack   = 1'b0;
    bus.i_user_rdata = '0;
    e = rd_q.pop_front();
    n_tot++;
    if ({bus.o_timeout, bus.o_read_data_valid, bus.o_read_data}
        !== {2'b01, e})
      $display("FAIL ack_terminal: got %b %b %h want 0 1 %h",
               bus.o_timeout, bus.o_read_data_valid,
               bus.o_read_data, e);
    else n_pass++;
    ready_hs();
  endtask

  task automatic test_reset_mid();
    int bad;
    addr_hs(16'h0060, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tot++;
    if ({bus.o_user_req, bus.o_read_data_valid, bus.o_addr_ready,
         bus.o_timeout} !== 4'b0010)
      $display("FAIL reset_mid: got %b want 0010",
               {bus.o_user_req, bus.o_read_data_valid,
                bus.o_addr_ready, bus.o_timeout});
    else n_pass++;
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.o_timeout || bus.o_user_req) bad++;
    end
    n_tot++;
    if (bad != 0)
      $display("FAIL reset_mid_quiet: got %0d bad cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_stray();
    logic [53:0] s0;
    int bad;
    @(negedge clk);
    s0 = snap();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      bus.i_write_data_valid = 1'b1;
      bus.i_user_ack         = 1'b1;
      bus.i_read_data_ready  = 1'b1;
      bus.i_common           = W'($urandom);
      bus.i_user_rdata       = W'($urandom);
      @(negedge clk);
      if (snap() !== s0) bad++;
    end
    idle_inputs();
    n_tot++;
    if (bad != 0)
      $display("FAIL stray: got %0d changed cycles want 0", bad);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    req_t e, g;
    logic [W-1:0] a, d, r, er;
    logic we;
    int bad;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      we = 1'($urandom_range(0, 1));
      a  = W'($urandom);
      d  = W'($urandom);
      r  = W'($urandom);
      if (we) begin
        addr_hs(a, 1'b1);
        req_q.push_back('{we: 1'b1, addr: a, wdata: d});
        wdata_hs(d);
      end else begin
        req_q.push_back('{we: 1'b0, addr: a, wdata: '0});
        addr_hs(a, 1'b0);
      end
      e = req_q.pop_front();
      g = '{we: bus.o_user_we, addr: bus.o_user_addr,
            wdata: e.we ? bus.o_user_wdata : '0};
      if (!bus.o_user_req || g !== e) begin
        bad++;
        $display("FAIL b2b_req: got %h want %h", g, e);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.i_user_ack   = 1'b1;
      bus.i_user_rdata = r;
      if (!we) rd_q.push_back(r);
      @(negedge clk);
      bus.i_user_ack   = 1'b0;
      bus.i_user_rdata = '0;
      if (!we) begin
        er = rd_q.pop_front();
        if (!bus.o_read_data_valid || bus.o_read_data !== er) begin
          bad++;
          $display("FAIL b2b_rd: got %h want %h", bus.o_read_data, er);
        end
        ready_hs();
      end
      if (!bus.o_addr_ready) bad++;
    end
    n_tot++;
    if (bad != 0)
      $display("FAIL back_to_back: got %0d errors want 0", bad);
    else n_pass++;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write();
    test_read();
    test_backpressure();
    test_stray();
    test_timeout_read();
    test_timeout_write();
    test_ack_terminal();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
